ula_scheduler: RTL and testbench
================================

ULA_SCHEDULER -- requirements
Module: ula_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width.
REQ-002 Parameter OPW, default 5, ULA opcode width.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  scheduler accepts requester n this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester n.
REQ-008 req0_opcode / req1_opcode  input  OPW  ULA opcode of requester n.
REQ-009 resp0_valid / resp1_valid  output  1  result for requester n available.
REQ-010 resp0_ready / resp1_ready  input  1  requester n consumes its result.
REQ-011 resp_out  output  WIDTH  registered ULA result, shared by both response ports.
REQ-012 resp_flag  output  1  registered ULA flag, shared by both response ports.
REQ-013 ula_a, ula_b  output  WIDTH  registered operands driven to the shared ULA.
REQ-014 ula_opcode  output  OPW  registered opcode driven to the shared ULA.
REQ-015 ula_out  input  WIDTH, ula_flag  input  1  combinational ULA result returned.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at a time.
REQ-017 In IDLE, reqN_ready SHALL be 1 for exactly the granted requester, else 0; both 0 in EXEC and RESP.
REQ-018 Grant SHALL be round-robin: if only one valid, grant it; if both valid, grant the requester not served last.
REQ-019 Last-served pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-020 Handshake completes when reqN_valid & reqN_ready; then ula_a/ula_b/ula_opcode SHALL load that requester's fields, owner SHALL record N, FSM -> EXEC.
REQ-021 In EXEC (exactly one cycle), resp_out/resp_flag SHALL capture ula_out/ula_flag; FSM -> RESP.
REQ-022 In RESP, respN_valid SHALL be 1 only for owner; resp_out/resp_flag SHALL hold stable until consumed.
REQ-023 On resp_owner_ready high in RESP: respN_valid drops next cycle, last-served pointer := owner, FSM -> IDLE.
REQ-024 Latency: request accept at cycle T -> respN_valid high at cycle T+2; earliest next accept T+3 when response consumed at T+2.
REQ-025 ula_a/ula_b/ula_opcode SHALL hold their last value outside the accept cycle (no glitching of the ULA).
REQ-026 Requesters dropping valid without handshake SHALL have no effect; no acceptance occurs outside IDLE.
REQ-027 resp_ready of the non-owner SHALL be ignored; resp_ready asserted before resp_valid SHALL be ignored.
REQ-028 No arithmetic inside the block; all widths pass through unchanged.

Reset
REQ-029 On reset high at a rising edge: FSM := IDLE, reqN_ready and respN_valid := 0 (registered view), resp_out := 0, resp_flag := 0, ula_a/ula_b := 0, ula_opcode := 0, pointer := 1.
REQ-030 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation with no response ever issued.
REQ-031 reqN_ready SHALL be 0 while reset is high.

Verification
REQ-032 Single request: req0 a=5,b=3,opcode=00001 at T with bench ULA model -> resp0_valid at T+2, resp_out=ULA(5,3,00001), resp1_valid stays 0.
REQ-033 Contention: both valid from reset, req0 a=1, req1 a=5 -> req0 served first, then req1; third contention grants req0 again (alternation).
REQ-034 Backpressure: resp1_ready held 0 for 10 cycles in RESP -> resp1_valid, resp_out, resp_flag stable; req0_ready 0 throughout; accept resumes one cycle after resp1_ready=1.
REQ-035 Flag path: opcode producing ula_flag=1 -> resp_flag=1 with correct owner; next op with flag 0 -> resp_flag=0.
REQ-036 Reset in RESP: assert reset while resp0_valid=1 -> next cycle all outputs at reset values, no stale response after release, req0 wins next contention.
REQ-037 Opcode sweep: all 32 opcodes a=5,b=0 via alternating requesters -> each resp_out equals ULA model output, ula_opcode stable during each EXEC.

Source files
------------

// File: rtl/ula_scheduler_if.sv
// Requester, response and shared-ULA signals of the ULA scheduler.
// The scheduler takes the slave view; the requester/ULA environment takes the master view.
interface ula_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [OPW-1:0]   req0_opcode;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req1_opcode;

    logic             resp0_valid;
    logic             resp0_ready;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp_out;
    logic             resp_flag;

    logic [WIDTH-1:0] ula_a;
    logic [WIDTH-1:0] ula_b;
    logic [OPW-1:0]   ula_opcode;
    logic [WIDTH-1:0] ula_out;
    logic             ula_flag;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_opcode,
        input  req1_valid, req1_a, req1_b, req1_opcode,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_out, resp_flag,
        input  resp0_ready, resp1_ready,
        output ula_a, ula_b, ula_opcode,
        input  ula_out, ula_flag
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_opcode,
        output req1_valid, req1_a, req1_b, req1_opcode,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_out, resp_flag,
        output resp0_ready, resp1_ready,
        input  ula_a, ula_b, ula_opcode,
        output ula_out, ula_flag
    );
endinterface

// File: rtl/ula_scheduler.sv
// Round-robin scheduler sharing one combinational ULA between two requesters.
// One operation in flight: accept in IDLE, capture the result in EXEC, hold it in RESP until consumed.
module ula_scheduler #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic           clock,
    input  logic           reset,
    ula_scheduler_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] ula_a_q, ula_a_d;
    logic [WIDTH-1:0] ula_b_q, ula_b_d;
    logic [OPW-1:0]   ula_opcode_q, ula_opcode_d;
    logic [WIDTH-1:0] resp_out_q, resp_out_d;
    logic             resp_flag_q, resp_flag_d;

    logic idle;
    logic grant0, grant1;
    logic rdy0, rdy1;
    logic accept0, accept1;
    logic owner_ready;

    // Under contention the requester that was not served last wins (last_q is the last owner).
    always_comb begin
        idle        = (state_q == IDLE) && !reset;
        grant0      = bus.req0_valid && (!bus.req1_valid || last_q);
        grant1      = bus.req1_valid && (!bus.req0_valid || !last_q);
        rdy0        = idle && grant0;
        rdy1        = idle && grant1;
        accept0     = rdy0 && bus.req0_valid;
        accept1     = rdy1 && bus.req1_valid;
        owner_ready = owner_q ? bus.resp1_ready : bus.resp0_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_opcode_d = ula_opcode_q;
        resp_out_d   = resp_out_q;
        resp_flag_d  = resp_flag_q;
        case (state_q)
            IDLE: begin
                if (accept0) begin
                    ula_a_d      = bus.req0_a;
                    ula_b_d      = bus.req0_b;
                    ula_opcode_d = bus.req0_opcode;
                    owner_d      = 1'b0;
                    state_d      = EXEC;
                end else if (accept1) begin
                    ula_a_d      = bus.req1_a;
                    ula_b_d      = bus.req1_b;
                    ula_opcode_d = bus.req1_opcode;
                    owner_d      = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_out_d  = bus.ula_out;
                resp_flag_d = bus.ula_flag;
                state_d     = RESP;
            end
            RESP: begin
                // Only the owner's ready retires the response; the other port is ignored.
                if (owner_ready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_opcode_q <= '0;
            resp_out_q   <= '0;
            resp_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_opcode_q <= ula_opcode_d;
            resp_out_q   <= resp_out_d;
            resp_flag_q  <= resp_flag_d;
        end
    end

    assign bus.req0_ready  = rdy0;
    assign bus.req1_ready  = rdy1;
    assign bus.resp0_valid = (state_q == RESP) && !owner_q;
    assign bus.resp1_valid = (state_q == RESP) && owner_q;
    assign bus.resp_out    = resp_out_q;
    assign bus.resp_flag   = resp_flag_q;
    assign bus.ula_a       = ula_a_q;
    assign bus.ula_b       = ula_b_q;
    assign bus.ula_opcode  = ula_opcode_q;
endmodule

// File: tb/tb_ula_scheduler.sv
// Bench for ula_scheduler: a transaction-level model checked every cycle plus directed scenarios
// with hand-computed results (single request, contention, backpressure, flag, reset in RESP, opcode sweep).
module tb_ula_scheduler;
    localparam int W  = 32;
    localparam int OW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ula_scheduler_if #(.WIDTH(W), .OPW(OW)) bus ();

    ula_scheduler #(.WIDTH(W), .OPW(OW)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference ULA: {flag, result}; flag marks a zero result.
    function automatic logic [W:0] ula_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OW-1:0] op);
        logic [W-1:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << b[4:0];
            5'd6:    r = a >> b[4:0];
            5'd7:    r = ~a;
            default: r = a + W'(op);
        endcase
        return {(r == '0), r};
    endfunction

    logic [W:0] ula_res;
    assign ula_res      = ula_fn(bus.ula_a, bus.ula_b, bus.ula_opcode);
    assign bus.ula_out  = ula_res[W-1:0];
    assign bus.ula_flag = ula_res[W];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: an operation is in flight from accept; one cycle later its result
    // exists, and it is offered to its owner until the owner consumes it.
    bit             m_busy = 1'b0;
    int             m_age  = 0;
    bit             m_own  = 1'b0;
    bit             m_last = 1'b1;
    logic [W-1:0]   m_a    = '0;
    logic [W-1:0]   m_b    = '0;
    logic [OW-1:0]  m_op   = '0;
    logic [W-1:0]   m_res  = '0;
    logic           m_flag = 1'b0;
    logic           e_rdy0, e_rdy1, e_rv0, e_rv1, own_rdy;
    logic [W:0]     m_tmp;

    always @(negedge clk) begin
        e_rdy0 = !reset && !m_busy && bus.req0_valid && (!bus.req1_valid || m_last == 1'b1);
        e_rdy1 = !reset && !m_busy && bus.req1_valid && (!bus.req0_valid || m_last == 1'b0);
        e_rv0  = m_busy && m_age >= 2 && m_own == 1'b0;
        e_rv1  = m_busy && m_age >= 2 && m_own == 1'b1;
        check("m_req0_ready",  bus.req0_ready,  e_rdy0);
        check("m_req1_ready",  bus.req1_ready,  e_rdy1);
        check("m_resp0_valid", bus.resp0_valid, e_rv0);
        check("m_resp1_valid", bus.resp1_valid, e_rv1);
        check("m_resp_out",    bus.resp_out,    m_res);
        check("m_resp_flag",   bus.resp_flag,   m_flag);
        check("m_ula_a",       bus.ula_a,       m_a);
        check("m_ula_b",       bus.ula_b,       m_b);
        check("m_ula_opcode",  bus.ula_opcode,  m_op);
        own_rdy = m_own ? bus.resp1_ready : bus.resp0_ready;
        if (reset) begin
            m_busy = 1'b0; m_age = 0; m_own = 1'b0; m_last = 1'b1;
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_flag = 1'b0;
        end else if (!m_busy) begin
            if (e_rdy0) begin
                m_busy = 1'b1; m_age = 1; m_own = 1'b0;
                m_a = bus.req0_a; m_b = bus.req0_b; m_op = bus.req0_opcode;
            end else if (e_rdy1) begin
                m_busy = 1'b1; m_age = 1; m_own = 1'b1;
                m_a = bus.req1_a; m_b = bus.req1_b; m_op = bus.req1_opcode;
            end
        end else if (m_age == 1) begin
            m_tmp  = ula_fn(m_a, m_b, m_op);
            m_res  = m_tmp[W-1:0];
            m_flag = m_tmp[W];
            m_age  = 2;
        end else if (own_rdy) begin
            m_busy = 1'b0;
            m_last = m_own;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input bit n, input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OW-1:0] op);
        if (n) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_opcode = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_opcode = op;
        end
    endtask

    // Present a lone request while idle; it must be accepted in the same cycle.
    task automatic issue(input bit n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [OW-1:0] op);
        set_req(n, 1'b1, a, b, op);
        settle();
        check("issue_ready", n ? bus.req1_ready : bus.req0_ready, 1'b1);
        tick();
        if (n) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    endtask

    task automatic wait_resp(input bit n, input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            settle();
            if ((n ? bus.resp1_valid : bus.resp0_valid) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("wait_resp", seen, 1'b1);
    endtask

    task automatic consume(input bit n);
        if (n) bus.resp1_ready = 1'b1; else bus.resp0_ready = 1'b1;
        tick();
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    bit          grants[$];
    logic [W-1:0] r0, r1;
    logic [W:0]  exp_sw;

    initial begin
        set_req(1'b0, 1'b0, '0, '0, '0);
        set_req(1'b1, 1'b0, '0, '0, '0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        reset = 1'b1;
        tick();
        bus.req0_valid = 1'b1;
        settle();
        check("rst_req0_ready", bus.req0_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        reset = 1'b0;
        settle();
        check("rst_resp_out", bus.resp_out, 32'd0);
        check("rst_ula_a", bus.ula_a, 32'd0);
        check("rst_resp0_valid", bus.resp0_valid, 1'b0);

        // Single request: ULA(5,3,sub) = 2, response two cycles after accept.
        tick();
        issue(1'b0, 32'd5, 32'd3, 5'd1);
        settle();
        check("single_t1_valid", bus.resp0_valid, 1'b0);
        tick();
        settle();
        check("single_t2_valid", bus.resp0_valid, 1'b1);
        check("single_resp_out", bus.resp_out, 32'd2);
        check("single_resp1_valid", bus.resp1_valid, 1'b0);
        consume(1'b0);
        settle();
        check("single_drop", bus.resp0_valid, 1'b0);

        // Contention from reset: grants must alternate 0,1,0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(1'b0, 1'b1, 32'd1, 32'd0, 5'd0);
        set_req(1'b1, 1'b1, 32'd5, 32'd0, 5'd0);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        r0 = '0; r1 = '0;
        for (int i = 0; i < 9; i++) begin
            settle();
            if (bus.req0_ready) grants.push_back(1'b0);
            if (bus.req1_ready) grants.push_back(1'b1);
            if (bus.resp0_valid) r0 = bus.resp_out;
            if (bus.resp1_valid) r1 = bus.resp_out;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        check("cont_count", grants.size(), 3);
        if (grants.size() == 3) begin
            check("cont_first", grants[0], 1'b0);
            check("cont_second", grants[1], 1'b1);
            check("cont_third", grants[2], 1'b0);
        end
        check("cont_r0", r0, 32'd1);
        check("cont_r1", r1, 32'd5);

        // Backpressure on requester 1: ULA(7,2,sub) = 5 held for 10 cycles.
        issue(1'b1, 32'd7, 32'd2, 5'd1);
        wait_resp(1'b1, 5);
        set_req(1'b0, 1'b1, 32'd9, 32'd1, 5'd0);
        bus.resp0_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            check("bp_valid", bus.resp1_valid, 1'b1);
            check("bp_out", bus.resp_out, 32'd5);
            check("bp_flag", bus.resp_flag, 1'b0);
            check("bp_req0_ready", bus.req0_ready, 1'b0);
            tick();
        end
        bus.resp1_ready = 1'b1;
        tick();
        bus.resp1_ready = 1'b0;
        settle();
        check("bp_resume", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        wait_resp(1'b0, 5);
        check("bp_next_out", bus.resp_out, 32'd10);
        tick();
        bus.resp0_ready = 1'b0;

        // Flag path: 3-3 = 0 raises the flag for owner 1; 1+2 = 3 clears it for owner 0.
        issue(1'b1, 32'd3, 32'd3, 5'd1);
        wait_resp(1'b1, 5);
        check("flag_set", bus.resp_flag, 1'b1);
        check("flag_owner0", bus.resp0_valid, 1'b0);
        consume(1'b1);
        issue(1'b0, 32'd1, 32'd2, 5'd0);
        wait_resp(1'b0, 5);
        check("flag_clr", bus.resp_flag, 1'b0);
        check("flag_out", bus.resp_out, 32'd3);
        consume(1'b0);

        // Reset while requester 0 holds a response; pointer must return to favour requester 0.
        issue(1'b0, 32'd4, 32'd4, 5'd0);
        wait_resp(1'b0, 5);
        reset = 1'b1;
        tick();
        settle();
        check("rr_resp0_valid", bus.resp0_valid, 1'b0);
        check("rr_resp_out", bus.resp_out, 32'd0);
        check("rr_flag", bus.resp_flag, 1'b0);
        check("rr_ula_a", bus.ula_a, 32'd0);
        check("rr_ula_b", bus.ula_b, 32'd0);
        check("rr_ula_op", bus.ula_opcode, 5'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            settle();
            check("rr_no_stale", bus.resp0_valid, 1'b0);
        end
        set_req(1'b0, 1'b1, 32'd1, 32'd0, 5'd0);
        set_req(1'b1, 1'b1, 32'd2, 32'd0, 5'd0);
        settle();
        check("rr_grant0", bus.req0_ready, 1'b1);
        check("rr_grant1", bus.req1_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_resp(1'b0, 5);
        consume(1'b0);

        // Opcode sweep with a=5, b=0 over alternating requesters.
        for (int op = 0; op < 32; op++) begin
            issue(op[0], 32'd5, 32'd0, op[4:0]);
            settle();
            check("sweep_exec_op", bus.ula_opcode, op[4:0]);
            wait_resp(op[0], 5);
            check("sweep_op_hold", bus.ula_opcode, op[4:0]);
            exp_sw = ula_fn(32'd5, 32'd0, op[4:0]);
            check("sweep_out", bus.resp_out, exp_sw[W-1:0]);
            consume(op[0]);
        end
        check("sweep_lit_op7", ula_fn(32'd5, 32'd0, 5'd7), {1'b0, 32'hFFFF_FFFA});

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
